// File: rtl/guess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : guess_pkg
//  Description : Shared types and default constants for the number-guessing
//                game (entry block, comparator, display decoder).
//  Revision    : 1.0 - initial release
// ============================================================================
package guess_pkg;

  // Top-level state of the player-entry block
  typedef enum logic [1:0] {
    EDIT    = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } entry_state_t;

  // Default digit geometry shared by all game blocks
  localparam int DIGIT_W_DEF   = 4;
  localparam int DIGIT_MAX_DEF = 9;

endpackage : guess_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Per-bit rising-edge detector. A level held high yields a
//                single one-cycle event. The history register clears on
//                reset so a button held through reset release still fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             restart,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_prev;

  // Remember last cycle's input level
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_prev <= '0;
    end else begin
      r_prev <= din;
    end
  end

  assign rise = din & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
//  Module      : guess_entry
//  Description : Player-entry block. Editable decimal digits driven by
//                per-digit up/down buttons, guess capture on confirm with a
//                valid/ack handshake to the comparator, saturating attempt
//                counter, and a lock state that freezes everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_entry
  import guess_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = DIGIT_W_DEF,
  parameter int DIGIT_MAX  = DIGIT_MAX_DEF,
  parameter int ATTEMPT_W  = 8,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          restart,
  input  logic [CNT_W-1:0]              max_digits,
  input  logic [NUM_DIGITS-1:0]         inc,
  input  logic [NUM_DIGITS-1:0]         dec,
  input  logic                          clear,
  input  logic                          confirm,
  input  logic                          lock,
  input  logic                          guess_ack,
  output logic [NUM_DIGITS*DIGIT_W-1:0] display_digits,
  output logic [NUM_DIGITS*DIGIT_W-1:0] guess_digits,
  output logic                          guess_valid,
  output logic [ATTEMPT_W-1:0]          attempts,
  output logic                          locked
);

  localparam int               c_VEC_W     = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] c_DIGIT_MAX = DIGIT_W'(DIGIT_MAX);

  logic [NUM_DIGITS-1:0] w_inc_ev;
  logic [NUM_DIGITS-1:0] w_dec_ev;
  logic [1:0]            w_ctl_ev;
  logic                  w_clear_ev;
  logic                  w_confirm_ev;
  logic                  w_frozen;
  logic [c_VEC_W-1:0]    w_display_next;

  entry_state_t          r_state;
  logic [c_VEC_W-1:0]    r_display;
  logic [c_VEC_W-1:0]    r_guess;
  logic                  r_valid;
  logic [ATTEMPT_W-1:0]  r_attempts;
  logic                  r_locked;

  // ---------------------------------------------------------------------------
  // Button edge detection, one detector per input group
  // ---------------------------------------------------------------------------
  rise_detect #(.WIDTH(NUM_DIGITS)) u_inc_rise (
    .clk     (clk),
    .restart (restart),
    .din     (inc),
    .rise    (w_inc_ev)
  );

  rise_detect #(.WIDTH(NUM_DIGITS)) u_dec_rise (
    .clk     (clk),
    .restart (restart),
    .din     (dec),
    .rise    (w_dec_ev)
  );

  rise_detect #(.WIDTH(2)) u_ctl_rise (
    .clk     (clk),
    .restart (restart),
    .din     ({clear, confirm}),
    .rise    (w_ctl_ev)
  );

  assign w_clear_ev   = w_ctl_ev[1];
  assign w_confirm_ev = w_ctl_ev[0];
  assign w_frozen     = (r_state == LOCKED);

  // ---------------------------------------------------------------------------
  // Per-digit next value: freeze, force-zero, clear, or wrap up/down
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [DIGIT_W-1:0] w_cur;
    logic [DIGIT_W-1:0] w_nxt;
    logic               w_active;

    assign w_cur    = r_display[gi*DIGIT_W +: DIGIT_W];
    // max_digits above NUM_DIGITS naturally activates every digit here
    assign w_active = (max_digits > CNT_W'(gi));

    // Choose the next digit value; clear beats inc/dec, opposing events cancel
    always_comb begin
      w_nxt = w_cur;
      if (w_frozen) begin
        w_nxt = w_cur;
      end else if (!w_active || w_clear_ev) begin
        w_nxt = '0;
      end else if (w_inc_ev[gi] && !w_dec_ev[gi]) begin
        w_nxt = (w_cur >= c_DIGIT_MAX) ? '0 : w_cur + 1'b1;
      end else if (w_dec_ev[gi] && !w_inc_ev[gi]) begin
        w_nxt = (w_cur == '0) ? c_DIGIT_MAX : w_cur - 1'b1;
      end
    end

    assign w_display_next[gi*DIGIT_W +: DIGIT_W] = w_nxt;
  end

  // Display register; the guess capture below reads the pre-edit value
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_display <= '0;
    end else begin
      r_display <= w_display_next;
    end
  end

  // Entry state machine: capture, handshake, attempts and lock
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      r_state    <= EDIT;
      r_guess    <= '0;
      r_valid    <= 1'b0;
      r_attempts <= '0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        EDIT: begin
          if (lock) begin
            r_state  <= LOCKED;
            r_valid  <= 1'b0;
            r_locked <= 1'b1;
          end else if (w_confirm_ev) begin
            r_state <= PENDING;
            r_guess <= r_display;
            r_valid <= 1'b1;
            if (r_attempts != '1) begin
              r_attempts <= r_attempts + 1'b1;
            end
          end
        end
        PENDING: begin
          if (lock) begin
            r_state  <= LOCKED;
            r_valid  <= 1'b0;
            r_locked <= 1'b1;
          end else if (guess_ack) begin
            r_state <= EDIT;
            r_valid <= 1'b0;
          end
        end
        LOCKED: begin
          r_state <= LOCKED;
        end
        default: begin
          r_state <= EDIT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign display_digits = r_display;
  assign guess_digits   = r_guess;
  assign guess_valid    = r_valid;
  assign attempts       = r_attempts;
  assign locked         = r_locked;

endmodule : guess_entry
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_entry
//  Description : Self-checking bench for guess_entry. Directed scenarios
//                followed by random stimulus, checked every cycle against an
//                array-based behavioural model of the entry rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

  localparam int ND   = 4;
  localparam int DW   = 4;
  localparam int DMAX = 9;
  localparam int AW   = 3;
  localparam int CW   = 3;
  localparam int AMAX = (1 << AW) - 1;

  logic             clk = 1'b0;
  logic             restart = 1'b0;
  logic [CW-1:0]    max_digits = '0;
  logic [ND-1:0]    inc = '0;
  logic [ND-1:0]    dec = '0;
  logic             clear = 1'b0;
  logic             confirm = 1'b0;
  logic             lock = 1'b0;
  logic             guess_ack = 1'b0;
  logic [ND*DW-1:0] display_digits;
  logic [ND*DW-1:0] guess_digits;
  logic             guess_valid;
  logic [AW-1:0]    attempts;
  logic             locked;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int       m_disp  [ND];
  int       m_guess [ND];
  bit       m_valid, m_pending, m_locked;
  int       m_att;
  bit [ND-1:0] p_inc, p_dec;
  bit       p_clr, p_cfm;

  guess_entry #(
    .NUM_DIGITS (ND),
    .DIGIT_W    (DW),
    .DIGIT_MAX  (DMAX),
    .ATTEMPT_W  (AW),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .restart        (restart),
    .max_digits     (max_digits),
    .inc            (inc),
    .dec            (dec),
    .clear          (clear),
    .confirm        (confirm),
    .lock           (lock),
    .guess_ack      (guess_ack),
    .display_digits (display_digits),
    .guess_digits   (guess_digits),
    .guess_valid    (guess_valid),
    .attempts       (attempts),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int a [ND]);
    logic [31:0] v = '0;
    for (int i = 0; i < ND; i++) v = v | (32'(a[i]) << (i * DW));
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_disp[i]  = 0;
      m_guess[i] = 0;
    end
    m_valid = 0; m_pending = 0; m_locked = 0; m_att = 0;
    p_inc = '0; p_dec = '0; p_clr = 0; p_cfm = 0;
  endtask

  // Apply the entry rules for one clock edge using the current inputs
  task automatic model_step();
    bit [ND-1:0] e_inc, e_dec;
    bit e_clr, e_cfm;
    int maxd;
    e_inc = inc & ~p_inc;
    e_dec = dec & ~p_dec;
    e_clr = clear & ~p_clr;
    e_cfm = confirm & ~p_cfm;
    p_inc = inc; p_dec = dec; p_clr = clear; p_cfm = confirm;
    maxd  = int'(max_digits);
    if (m_locked) return;
    if (lock) begin
      m_locked = 1; m_valid = 0; m_pending = 0;
    end else if (!m_pending && e_cfm) begin
      m_guess   = m_disp;
      m_valid   = 1;
      m_pending = 1;
      if (m_att < AMAX) m_att++;
    end else if (m_pending && guess_ack) begin
      m_valid = 0; m_pending = 0;
    end
    for (int i = 0; i < ND; i++) begin
      if (i >= maxd || e_clr) m_disp[i] = 0;
      else if (e_inc[i] && !e_dec[i]) m_disp[i] = (m_disp[i] + 1) % (DMAX + 1);
      else if (e_dec[i] && !e_inc[i]) m_disp[i] = (m_disp[i] + DMAX) % (DMAX + 1);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".disp"},   32'(display_digits), pack(m_disp));
    chk({tag, ".guess"},  32'(guess_digits),   pack(m_guess));
    chk({tag, ".valid"},  32'(guess_valid),    32'(m_valid));
    chk({tag, ".att"},    32'(attempts),       32'(m_att));
    chk({tag, ".locked"}, 32'(locked),         32'(m_locked));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic press(input logic [ND-1:0] im, input logic [ND-1:0] dm);
    inc = im; dec = dm;
    tick();
    inc = '0; dec = '0;
    tick();
  endtask

  // Assert restart between edges and check the asynchronous clear
  task automatic do_reset();
    #2;
    restart = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    restart = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("por");
    @(negedge clk);
    restart = 1'b1;

    // Digit wrap up through 9 and down from 0
    max_digits = 3'd3;
    for (int k = 0; k < 10; k++) press(4'b0001, 4'b0000);
    chk("wrap_up_d0", 32'(display_digits[0 +: DW]), 32'd0);
    press(4'b0010, 4'b0000);
    press(4'b0000, 4'b0010);
    press(4'b0000, 4'b0010);
    chk("wrap_dn_d1", 32'(display_digits[DW +: DW]), 32'd9);

    // Inactive digit ignores buttons; shrinking max_digits zeroes digits
    max_digits = 3'd2;
    press(4'b0100, 4'b0000);
    chk("inactive_d2", 32'(display_digits[2*DW +: DW]), 32'd0);
    for (int k = 0; k < 6; k++) press(4'b0010, 4'b0000);
    chk("d1_five", 32'(display_digits[DW +: DW]), 32'd5);
    max_digits = 3'd1;
    tick();
    chk("shrink_d1", 32'(display_digits[DW +: DW]), 32'd0);

    // Build 4,7,2 then hold confirm for five cycles
    max_digits = 3'd3;
    for (int k = 0; k < 4; k++) press(4'b0001, 4'b0000);
    for (int k = 0; k < 7; k++) press(4'b0010, 4'b0000);
    for (int k = 0; k < 2; k++) press(4'b0100, 4'b0000);
    confirm = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    confirm = 1'b0;
    tick();
    chk("cap_guess", 32'(guess_digits), 32'h0274);
    chk("cap_valid", 32'(guess_valid), 32'd1);
    chk("cap_att", 32'(attempts), 32'd1);
    confirm = 1'b1; tick(); confirm = 1'b0; tick();
    chk("pend_att", 32'(attempts), 32'd1);

    // Opposing events cancel; ack then immediate confirm with an edit
    press(4'b0001, 4'b0001);
    chk("incdec_d0", 32'(display_digits[0 +: DW]), 32'd4);
    guess_ack = 1'b1; tick(); guess_ack = 1'b0;
    chk("ack_valid", 32'(guess_valid), 32'd0);
    confirm = 1'b1; inc = 4'b0001; tick();
    chk("cfm_inc_guess", 32'(guess_digits[0 +: DW]), 32'd4);
    chk("cfm_inc_disp", 32'(display_digits[0 +: DW]), 32'd5);
    chk("att_two", 32'(attempts), 32'd2);
    confirm = 1'b0; inc = '0; tick();

    // Saturate the attempt counter
    for (int k = 0; k < 7; k++) begin
      guess_ack = 1'b1; tick(); guess_ack = 1'b0;
      confirm = 1'b1; tick(); confirm = 1'b0; tick();
    end
    chk("att_sat", 32'(attempts), 32'(AMAX));

    // Lock wins over ack; everything frozen afterwards
    lock = 1'b1; guess_ack = 1'b1; tick();
    lock = 1'b0; guess_ack = 1'b0;
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_valid", 32'(guess_valid), 32'd0);
    press(4'b1111, 4'b0000);
    clear = 1'b1; confirm = 1'b1; tick(); clear = 1'b0; confirm = 1'b0; tick();
    chk("lock_att", 32'(attempts), 32'(AMAX));
    do_reset();
    chk("rst_att", 32'(attempts), 32'd0);

    // Reset in the middle of a pending handshake
    max_digits = 3'd4;
    press(4'b1111, 4'b0000);
    confirm = 1'b1; tick(); confirm = 1'b0; tick();
    chk("pend_before_rst", 32'(guess_valid), 32'd1);
    do_reset();
    chk("rst_valid", 32'(guess_valid), 32'd0);

    // Random stimulus against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) max_digits = CW'($urandom_range(0, 7));
      inc       = ND'($urandom);
      dec       = ND'($urandom);
      clear     = ($urandom_range(0, 7) == 0);
      confirm   = 1'($urandom);
      guess_ack = 1'($urandom);
      lock      = ($urandom_range(0, 149) == 0);
      tick();
      if (m_locked && $urandom_range(0, 9) == 0) do_reset();
      else if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_guess_entry
`default_nettype wire

// File: doc/guess_entry.md
# guess_entry

Parametrised player-entry block for the number-guessing game. It holds up to NUM_DIGITS editable decimal digits driven by per-digit increment/decrement pushbuttons. Entry is limited to the active digit count set by difficulty. On confirm, the block captures a guess and presents it to the comparator over a valid/ack handshake, counts attempts, and freezes when the game locks.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digit positions.
- DIGIT_W, 4, bits per digit.
- DIGIT_MAX, 9, largest digit value. Digits wrap between 0 and DIGIT_MAX. Must be < 2**DIGIT_W.
- ATTEMPT_W, 8, attempt counter width.
- CNT_W, $clog2(NUM_DIGITS+1), width of max_digits.

Ports:
- clk  in  1  single system clock.
- restart  in  1  reset. Asynchronous assert, active-low.
- max_digits  in  CNT_W  number of active digits, counted from digit 0. Values > NUM_DIGITS are treated as NUM_DIGITS.
- inc  in  NUM_DIGITS  per-digit increment buttons. Level inputs, debounced and synchronous upstream.
- dec  in  NUM_DIGITS  per-digit decrement buttons. Same conditioning as inc.
- clear  in  1  level input. Zeroes all display digits on its rising edge.
- confirm  in  1  level input. Captures the guess on its rising edge.
- lock  in  1  game over. Level, sampled every cycle.
- guess_ack  in  1  comparator accepts the guess.
- display_digits  out  NUM_DIGITS*DIGIT_W  current edit value. Digit i is at bits [i*DIGIT_W +: DIGIT_W].
- guess_digits  out  NUM_DIGITS*DIGIT_W  captured guess. Stable while guess_valid is high.
- guess_valid  out  1  captured guess awaiting ack.
- attempts  out  ATTEMPT_W  confirmed guesses since reset. Saturating.
- locked  out  1  block is in the LOCKED state.

## Operation
- Button events: all of inc, dec, clear and confirm are rising-edge detected against a registered copy of the previous input value. A held button produces exactly one event.
- States: EDIT, PENDING, LOCKED.
- EDIT:
  - inc event on an active digit: increments the digit, DIGIT_MAX wraps to 0.
  - dec event on an active digit: decrements the digit, 0 wraps to DIGIT_MAX.
  - inc and dec events on the same digit in the same cycle: digit unchanged.
  - Events on different digits in the same cycle are all applied.
- Inactive digits (index >= max_digits):
  - Forced to 0 on every clock.
  - Their buttons are ignored.
  - If max_digits is reduced, the affected digits read 0 from the next cycle.
- clear event: all display digits become 0. If it coincides with inc/dec events, clear wins.
- confirm event in EDIT:
  - guess_digits <= display_digits. Any inc/dec/clear in the same cycle is applied to the display only after the capture, so the guess holds the pre-event value.
  - guess_valid <= 1.
  - attempts <= attempts+1, saturating at all ones.
  - State moves to PENDING.
- PENDING:
  - Display editing continues exactly as in EDIT. guess_digits is held.
  - confirm events are ignored.
  - guess_ack high: guess_valid <= 0 and state moves to EDIT.
- lock high in EDIT or PENDING:
  - State moves to LOCKED and guess_valid <= 0.
  - lock has priority over guess_ack and confirm in the same cycle.
- LOCKED:
  - All buttons and guess_ack are ignored. Display, guess and attempts are frozen.
  - Only restart leaves LOCKED.
- Reset values:
  - State EDIT.
  - All digits 0 and guess_digits 0.
  - guess_valid 0, attempts 0, locked 0.
  - Edge-detect registers 0, so a button held through reset release produces one event.
- Reset mid-handshake: guess_valid drops asynchronously. The comparator must discard the pending guess.

## Timing
- All outputs are registered.
- Button event to display_digits change: the input is sampled high at edge k and the new value is visible after edge k, a latency of 1 cycle.
- confirm sampled at edge k: guess_digits, guess_valid and attempts update after edge k.
- guess_ack sampled high at edge m while PENDING: guess_valid is low after edge m. The earliest next accepted confirm is at edge m+1.
- guess_ack outside PENDING has no effect.
- lock sampled at edge k: locked=1 after edge k.
- restart asserts asynchronously. Release is synchronous to clk, handled upstream.

## Structure
- Package guess_pkg holds:
  - typedef enum logic [1:0] {EDIT, PENDING, LOCKED} entry_state_t.
  - Default constants DIGIT_W_DEF=4 and DIGIT_MAX_DEF=9, shared with the comparator and display decoder.
- Sub-module rise_detect, parametrised WIDTH:
  - Registers the input and outputs in & ~prev.
  - Uses the same clk/restart.
  - Instanced once per input group: inc, dec, and {clear, confirm}.
- Per-digit up/down wrap logic is a generate loop in guess_entry.

## Test plan
- Reset, max_digits=3, pulse inc[0] ten times -> digit0 steps 1..9 then 0. Pulse dec[1] once -> digit1=9.
- max_digits=2, pulse inc[2] -> digit2 stays 0. Set digit1=5, then max_digits=1 -> digit1 reads 0 next cycle.
- Display 4,7,2 and confirm held for 5 cycles -> exactly one capture: guess_digits=4,7,2, guess_valid=1, attempts=1. A second confirm while PENDING -> no change.
- inc[0] and dec[0] in the same cycle -> digit0 unchanged. Confirm and inc[0] in the same cycle with digit0=3 -> guess digit0=3, display digit0=4.
- guess_ack at cycle m -> guess_valid=0 after edge m. Confirm at m+1 -> accepted, attempts=2. With ATTEMPT_W=2, five confirm/ack cycles -> attempts saturates at 3.
- lock and guess_ack together while PENDING -> locked=1, guess_valid=0, buttons ignored. restart low mid-PENDING -> all outputs 0 immediately, state EDIT.
